fetch_decode_unit: RTL

Upstream stage of the 8-bit CPU: holds a small writable program store, sequences a program counter, fetches and decodes each instruction word, and presents operands `a`, `b`, `opcode` and the `save` strobe to the execute/instruction-memory stage through a valid/ready handshake. It replaces the testbench-driven operand stimulus with a program-driven one, so a loaded program runs the ALU ops (add, sub, and, or, xor, mul, div, comp) autonomously until a halt word.

---
 rtl/fetch_decode_unit_if.sv | 20 ++
 rtl/fetch_decode_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit_if.sv
// Issue handshake between fetch/decode and the execute stage.
// master drives operands and issue_valid; slave returns exec_ready.
interface fetch_decode_unit_if;
    logic       issue_valid;
    logic       exec_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic       save;

    modport master (
        output issue_valid, a, b, opcode, save,
        input  exec_ready
    );

    modport slave (
        input  issue_valid, a, b, opcode, save,
        output exec_ready
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: program store, pc sequencer and decoder feeding execute.
// Define FETCH_LOOP_EN to wrap pc at the end of the store instead of halting.
module fetch_decode_unit #(
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [20:0]         prog_data,
    input  logic                start,
    fetch_decode_unit_if.master iss,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [20:0]       mem_q [2**ADDR_W];
    logic [20:0]       rdata_q;
    logic [19:0]       ir_q;
    logic              issue_valid_q;
    logic              busy_q;
    logic              halted_q;
    logic              store_we_d;
    logic              fire_d;

    assign pc_inc_d = pc_q + 1'b1;
    assign fire_d   = issue_valid_q && iss.exec_ready;

    // Loading is only allowed while no program is running.
    assign store_we_d = prog_we && !reset &&
                        (state_q == IDLE || state_q == HALTED);

    // Program store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_we_d) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Registered read port; the word appears one cycle after FETCH.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[pc_q];
    end

    // Sequencer with registered issue and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        pc_q     <= '0;
                        state_q  <= FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    // Halt words are never latched, so operands keep
                    // the last issued instruction.
                    if (rdata_q[20]) begin
                        state_q  <= HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        ir_q          <= rdata_q[19:0];
                        state_q       <= ISSUE;
                        issue_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fire_d) begin
                        issue_valid_q <= 1'b0;
                        if (pc_q == PC_LAST) begin
`ifdef FETCH_LOOP_EN
                            pc_q    <= '0;
                            state_q <= FETCH;
`else
                            state_q  <= HALTED;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
`endif
                        end else begin
                            pc_q    <= pc_inc_d;
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign iss.issue_valid = issue_valid_q;
    assign iss.opcode      = ir_q[19:17];
    assign iss.save        = ir_q[16];
    assign iss.a           = ir_q[15:8];
    assign iss.b           = ir_q[7:0];
    assign pc              = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
endmodule
